// File: rtl/control_unit.sv
// Main decoder: 6-bit opcode in, nine registered datapath control strobes out.
// Define CONTROL_UNIT_ADDI_EN to also decode addi (001000); otherwise it is an undecoded opcode.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] ins_opCode,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic       ALUOp1,
    output logic       ALUOp0
);

    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic       memToReg;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic [1:0] aluOp;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    ctrl_t ctrlD;
    ctrl_t ctrlQ;

    // Unlisted opcodes fall through to all-zero so nothing writes state.
    always_comb begin
        ctrlD = '0;
        case (ins_opCode)
            OP_RTYPE: begin
                ctrlD.regDst   = 1'b1;
                ctrlD.regWrite = 1'b1;
                ctrlD.aluOp    = ALU_FUNCT;
            end
            OP_LW: begin
                ctrlD.aluSrc   = 1'b1;
                ctrlD.memToReg = 1'b1;
                ctrlD.regWrite = 1'b1;
                ctrlD.memRead  = 1'b1;
                ctrlD.aluOp    = ALU_ADD;
            end
            OP_SW: begin
                ctrlD.aluSrc   = 1'b1;
                ctrlD.memWrite = 1'b1;
                ctrlD.aluOp    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrlD.branch   = 1'b1;
                ctrlD.aluOp    = ALU_SUB;
            end
`ifdef CONTROL_UNIT_ADDI_EN
            OP_ADDI: begin
                ctrlD.aluSrc   = 1'b1;
                ctrlD.regWrite = 1'b1;
                ctrlD.aluOp    = ALU_ADD;
            end
`endif
            default: ctrlD = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ctrlQ <= '0;
        else        ctrlQ <= ctrlD;
    end

    assign RegDst   = ctrlQ.regDst;
    assign ALUSrc   = ctrlQ.aluSrc;
    assign MemtoReg = ctrlQ.memToReg;
    assign RegWrite = ctrlQ.regWrite;
    assign MemRead  = ctrlQ.memRead;
    assign MemWrite = ctrlQ.memWrite;
    assign Branch   = ctrlQ.branch;
    assign ALUOp1   = ctrlQ.aluOp[1];
    assign ALUOp0   = ctrlQ.aluOp[0];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed sequences plus random opcode/reset traffic against a lookup-table model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] ins_opCode;
    logic RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0;

    int checks   = 0;
    int failures = 0;

    logic [8:0] tbl [int];

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .ins_opCode(ins_opCode),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .ALUOp1(ALUOp1), .ALUOp0(ALUOp0)
    );

    function automatic logic [8:0] refDecode(input logic [5:0] op);
        int key;
        key = int'(op);
        return tbl.exists(key) ? tbl[key] : 9'b0;
    endfunction

    function automatic logic [8:0] outs();
        return {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0};
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = outs();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
        checks++;
        assert (!(MemRead === 1'b1 && MemWrite === 1'b1) && !(ALUOp1 === 1'b1 && ALUOp0 === 1'b1)) else begin
            failures++;
            $error("FAIL %s_invariant got=%b exp=no_rd_wr_or_aluop11", tag, got);
        end
    endtask

    // Drive, take one rising edge, sample 1 time unit later.
    task automatic step(input string tag, input logic rst, input logic [5:0] op);
        rst_n      = rst;
        ins_opCode = op;
        @(posedge clk);
        #1;
        check(tag, rst ? refDecode(op) : 9'b0);
    endtask

    initial begin
        tbl[0]  = 9'b100100010;   // R-type
        tbl[35] = 9'b011110000;   // lw
        tbl[43] = 9'b010001000;   // sw
        tbl[4]  = 9'b000000101;   // beq
`ifdef CONTROL_UNIT_ADDI_EN
        tbl[8]  = 9'b010100000;   // addi
`endif

        rst_n = 1'b0;
        ins_opCode = 6'b000000;
        @(negedge clk);

        step("reset_edge1", 1'b0, 6'b000000);
        step("reset_edge2", 1'b0, 6'b000000);

        step("seq_rtype", 1'b1, 6'b000000);
        step("seq_lw",    1'b1, 6'b100011);
        step("seq_sw",    1'b1, 6'b101011);
        step("seq_beq",   1'b1, 6'b000100);
        step("seq_undef", 1'b1, 6'b111100);

        step("mid_lw", 1'b1, 6'b100011);
        #2 ins_opCode = 6'b101011;
        #2 check("mid_hold_lw", 9'b011110000);
        @(posedge clk);
        #1 check("mid_sw", 9'b010001000);

        step("rst_mid_lw",    1'b1, 6'b100011);
        step("rst_mid_clear", 1'b0, 6'b100011);
        step("rst_mid_back",  1'b1, 6'b100011);

        step("addi", 1'b1, 6'b001000);

        for (int i = 0; i < 64; i++)
            step($sformatf("sweep_%02h", i), 1'b1, 6'(i));

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic       r;
            case ($urandom_range(0, 3))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000100;
                default: op = 6'($urandom_range(0, 63));
            endcase
            r = ($urandom_range(0, 7) != 0);
            step($sformatf("rand_%0d", i), r, op);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ins_opCode  input  6  instruction opcode field, bits [31:26] of the instruction.
- RegDst  output  1  1 = destination register is rd; 0 = rt.
- ALUSrc  output  1  1 = ALU operand B is the sign-extended immediate; 0 = register rt.
- MemtoReg  output  1  1 = write-back data comes from data memory; 0 = from the ALU.
- RegWrite  output  1  register file write enable.
- MemRead  output  1  data memory read enable.
- MemWrite  output  1  data memory write enable.
- Branch  output  1  conditional-branch (beq) indicator.
- ALUOp1  output  1  ALU operation class, MSB.
- ALUOp0  output  1  ALU operation class, LSB.

REQ-002 One clock; reset is synchronous and active-low.

Function
REQ-003 All nine outputs SHALL be registered, driven directly from flip-flops, with no combinational path from ins_opCode to any output.
REQ-004 Latency SHALL be one cycle: the outputs after rising edge N reflect the ins_opCode sampled at edge N.
REQ-005 Decode table (bits in order RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0):
- 000000 (R-type): 1 0 0 1 0 0 0 1 0
- 100011 (lw): 0 1 1 1 1 0 0 0 0
- 101011 (sw): 0 1 0 0 0 1 0 0 0
- 000100 (beq): 0 0 0 0 0 0 1 0 1
REQ-006 For sw and beq, the don't-care fields (RegDst, MemtoReg) SHALL be driven 0.
REQ-007 Any opcode not decoded (for example 111100) SHALL produce all nine outputs 0 on the next edge, so no register or memory write can occur.
REQ-008 ALUOp encoding SHALL be: {ALUOp1,ALUOp0} = 00 for add (address calculation), 01 for subtract (compare), 10 for funct-field decode; 11 SHALL never be produced.
REQ-009 MemRead and MemWrite SHALL never both be 1 in the same cycle.
REQ-010 Decode SHALL be a full 6-bit exact match; no partial or wildcard match.
REQ-011 When the opcode changes between edges, the outputs SHALL change only at the next rising edge and SHALL be glitch-free.

Reset
REQ-012 When rst_n = 0 at a rising edge, all nine outputs SHALL become 0, regardless of ins_opCode.
REQ-013 Reset SHALL take priority over decode. The first decoded value SHALL appear at the first rising edge at which rst_n = 1.
REQ-014 If reset is asserted mid-stream, the outputs SHALL clear at that edge, and no stale decode SHALL persist after reset is released.

Configuration
REQ-015 Macro CONTROL_UNIT_ADDI_EN:
- Defined: opcode 001000 (addi) SHALL decode to 0 1 0 1 0 0 0 0 0.
- Undefined: 001000 SHALL be treated as an undecoded opcode (all outputs 0).
- All other decode rows SHALL be identical in both builds.

Verification
REQ-016 Hold rst_n = 0 with ins_opCode = 000000 for 2 edges -> all outputs 0.
REQ-017 After reset release, apply 000000, then 100011, 101011, 000100, 111100, one per clock -> outputs follow the REQ-005 rows in sequence, then all 0, each one edge after its opcode is applied.
REQ-018 Change ins_opCode mid-cycle from 100011 to 101011 -> outputs stay at the lw row until the next rising edge, then switch to the sw row.
REQ-019 Apply 100011, then assert rst_n = 0 for one edge -> all outputs 0 at that edge; after release with 100011 still applied, the lw row returns one edge later.
REQ-020 Apply 001000 -> with CONTROL_UNIT_ADDI_EN defined, 0 1 0 1 0 0 0 0 0; without it, all 0.
REQ-021 Sweep all 64 opcodes -> exact match to the table for every opcode, and neither MemRead = MemWrite = 1 nor ALUOp = 11 ever occurs.
